// File: rtl/mem_pkg.sv
// Shared definitions for the memory bank: controller state encoding and request-type constants.
// No logic; types and constants only.
// Not applicable.
package mem_pkg;

    // Controller states: CLEAR walks the array writing zeros, IDLE serves requests.
    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    // Request type carried on the mode input.
    localparam logic MODE_READ  = 1'b1;
    localparam logic MODE_WRITE = 1'b0;

endpackage

// File: rtl/mem_array.sv
// Word storage with one byte-enabled write port and one registered read port.
// Latency: write lands at the edge, read data appears one cycle after rd_en.
// No backpressure; every enabled access completes. rd_data holds between reads.
module mem_array #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic                rd_en,
    input  logic                rd_zero,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [DATA_W-1:0]   rd_data
);

    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    // Byte-lane write: only lanes with their enable set are touched.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (wr_be[b]) begin
                    mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

    // Registered read; rd_zero forces a zero word (out-of-range) without touching the array.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= rd_zero ? '0 : mem[rd_addr];
        end
    end

endmodule

// File: rtl/mem_bank.sv
// Memory bank controller: clear sequencer, request handshake, range check over mem_array.
// Latency: read response one cycle after acceptance; writes visible to the next cycle's read.
// req_ready drops while clearing (DEPTH cycles) and in any cycle clr is asserted.
module mem_bank
    import mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                mode,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W-1:0]   data_in,
    input  logic [DATA_W/8-1:0] byte_en,
    output logic                rsp_valid,
    output logic                rsp_err,
    output logic [DATA_W-1:0]   data_out
);

    // One extra bit so DEPTH == 2**ADDR_W is representable in the range compare.
    localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    state_t              state;
    logic [ADDR_W-1:0]   cnt;

    logic                in_range;
    logic                acc;
    logic                rd_acc;
    logic                wr_acc;
    logic                clearing;

    logic                arr_wr_en;
    logic [ADDR_W-1:0]   arr_wr_addr;
    logic [DATA_W-1:0]   arr_wr_data;
    logic [DATA_W/8-1:0] arr_wr_be;

    // Handshake and request decode; out-of-range writes are silently dropped.
    always_comb begin
        in_range  = ({1'b0, address} < DEPTH_W);
        clearing  = (state == CLEAR);
        req_ready = (state == IDLE) && !clr;
        acc       = req_valid && req_ready;
        rd_acc    = acc && (mode == MODE_READ);
        wr_acc    = acc && (mode == MODE_WRITE) && in_range;
    end

    // Write-port mux: the clear sequencer owns the port while clearing.
    always_comb begin
        arr_wr_en   = rst_n && (clearing || wr_acc);
        arr_wr_addr = clearing ? cnt : address;
        arr_wr_data = clearing ? '0  : data_in;
        arr_wr_be   = clearing ? '1  : byte_en;
    end

    // Controller FSM with clear counter and registered response flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= CLEAR;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= rd_acc;
            rsp_err   <= rd_acc && !in_range;
            case (state)
                CLEAR: begin
                    if (clr) begin
                        cnt <= '0;
                    end else if (cnt == LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (clr) begin
                        state <= CLEAR;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= CLEAR;
                    cnt   <= '0;
                end
            endcase
        end
    end

    mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (arr_wr_en),
        .wr_addr (arr_wr_addr),
        .wr_data (arr_wr_data),
        .wr_be   (arr_wr_be),
        .rd_en   (rd_acc),
        .rd_zero (!in_range),
        .rd_addr (address),
        .rd_data (data_out)
    );

endmodule

// File: tb/tb_mem_bank.sv
// Directed bench for mem_bank: a default-size bank and a DEPTH=200 bank driven in lockstep.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// Requests are only issued when both banks report ready.
module tb_mem_bank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        req_valid;
    logic        mode;
    logic [7:0]  address;
    logic [31:0] data_in;
    logic [3:0]  byte_en;

    logic        rdy_a, vld_a, err_a;
    logic [31:0] dat_a;
    logic        rdy_b, vld_b, err_b;
    logic [31:0] dat_b;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mem_bank u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .req_valid (req_valid),
        .req_ready (rdy_a),
        .mode      (mode),
        .address   (address),
        .data_in   (data_in),
        .byte_en   (byte_en),
        .rsp_valid (vld_a),
        .rsp_err   (err_a),
        .data_out  (dat_a)
    );

    mem_bank #(.DEPTH(200)) u_dut200 (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .req_valid (req_valid),
        .req_ready (rdy_b),
        .mode      (mode),
        .address   (address),
        .data_in   (data_in),
        .byte_en   (byte_en),
        .rsp_valid (vld_b),
        .rsp_err   (err_b),
        .data_out  (dat_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request presented for exactly one edge.
    task automatic req(input logic m, input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        req_valid = 1'b1;
        mode      = m;
        address   = a;
        data_in   = d;
        byte_en   = be;
        tick();
        req_valid = 1'b0;
    endtask

    // Counts not-ready cycles of each bank until both are ready (bounded).
    task automatic wait_ready(output int na, output int nb);
        na = 0;
        nb = 0;
        for (int i = 0; i < 1000 && !(rdy_a && rdy_b); i++) begin
            if (!rdy_a) na++;
            if (!rdy_b) nb++;
            tick();
        end
    endtask

    int na, nb;

    initial begin
        rst_n = 1'b0; clr = 1'b0; req_valid = 1'b0; mode = 1'b0;
        address = '0; data_in = '0; byte_en = '0;

        // Reset state
        tick();
        check("rst_vld",  vld_a, 1'b0);
        check("rst_err",  err_a, 1'b0);
        check("rst_dat",  dat_a, 32'h0);
        check("rst_rdy",  rdy_a, 1'b0);
        rst_n = 1'b1;

        // Clear after reset takes DEPTH cycles
        wait_ready(na, nb);
        check("clr_cycles_256", na, 256);
        check("clr_cycles_200", nb, 200);
        req(1'b1, 8'd5, 32'h0, 4'h0);
        check("rd5_vld", vld_a, 1'b1);
        check("rd5_dat", dat_a, 32'h0);
        check("rd5_err", err_a, 1'b0);

        // Back-to-back writes and reads
        req(1'b0, 8'd2, 32'd30, 4'hF);
        check("wr2_novld", vld_a, 1'b0);
        req(1'b0, 8'd4, 32'd40, 4'hF);
        req(1'b1, 8'd2, 32'h0, 4'h0);
        check("b2b_vld0", vld_a, 1'b1);
        check("b2b_dat0", dat_a, 32'd30);
        req(1'b1, 8'd4, 32'h0, 4'h0);
        check("b2b_vld1", vld_a, 1'b1);
        check("b2b_dat1", dat_a, 32'd40);
        tick();
        check("pulse_end", vld_a, 1'b0);
        check("dat_hold",  dat_a, 32'd40);

        // Byte-lane merge, read immediately after write
        req(1'b0, 8'd7, 32'h11223344, 4'hF);
        req(1'b0, 8'd7, 32'hAABBCCDD, 4'b0101);
        req(1'b1, 8'd7, 32'h0, 4'h0);
        check("be_merge_a", dat_a, 32'h11BB33DD);
        check("be_merge_b", dat_b, 32'h11BB33DD);
        req(1'b0, 8'd7, 32'hFFFFFFFF, 4'b0000);
        req(1'b1, 8'd7, 32'h0, 4'h0);
        check("be_none", dat_a, 32'h11BB33DD);

        // Range check: 210 is valid for 256, out of range for 200
        req(1'b0, 8'd210, 32'h55, 4'hF);
        req(1'b1, 8'd210, 32'h0, 4'h0);
        check("oor_dat_200", dat_b, 32'h0);
        check("oor_err_200", err_b, 1'b1);
        check("oor_vld_200", vld_b, 1'b1);
        check("in_dat_256",  dat_a, 32'h55);
        check("in_err_256",  err_a, 1'b0);
        req(1'b1, 8'd199, 32'h0, 4'h0);
        check("last_dat_200", dat_b, 32'h0);
        check("last_err_200", err_b, 1'b0);

        // clr in IDLE blocks the concurrent write and clears everything
        req(1'b0, 8'd3, 32'h12345678, 4'hF);
        clr = 1'b1; req_valid = 1'b1; mode = 1'b0; address = 8'd3;
        data_in = 32'hDEADBEEF; byte_en = 4'hF;
        #1;
        check("clr_rdy_low", rdy_a, 1'b0);
        tick();
        clr = 1'b0; req_valid = 1'b0;
        check("clr_no_vld", vld_a, 1'b0);
        wait_ready(na, nb);
        check("clr2_cycles_256", na, 256);
        check("clr2_cycles_200", nb, 200);
        req(1'b1, 8'd3, 32'h0, 4'h0);
        check("clr_rd3", dat_a, 32'h0);
        req(1'b1, 8'd7, 32'h0, 4'h0);
        check("clr_rd7", dat_a, 32'h0);

        // clr during CLEAR restarts the count
        clr = 1'b1; tick(); clr = 1'b0;
        repeat (50) tick();
        clr = 1'b1; tick(); clr = 1'b0;
        wait_ready(na, nb);
        check("reclr_cycles_256", na, 256);

        // Reset at clear count 100 restarts the full clear
        req(1'b0, 8'd9, 32'hCAFEF00D, 4'hF);
        req(1'b1, 8'd9, 32'h0, 4'h0);
        clr = 1'b1; tick(); clr = 1'b0;
        repeat (100) tick();
        check("hold_in_clear", dat_a, 32'hCAFEF00D);
        check("no_vld_clear",  vld_a, 1'b0);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        check("rst2_dat", dat_a, 32'h0);
        check("rst2_vld", vld_a, 1'b0);
        wait_ready(na, nb);
        check("rst2_cycles_256", na, 256);
        check("rst2_cycles_200", nb, 200);
        req(1'b1, 8'd9, 32'h0, 4'h0);
        check("rst2_rd9", dat_a, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_bank.md
MEM_BANK -- requirements
Module: mem_bank

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, data word width (multiple of 8).
REQ-002 The block SHALL have parameter ADDR_W, default 8, address width.
REQ-003 The block SHALL have parameter DEPTH, default 256, number of words (1..2**ADDR_W).
REQ-004 The block SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-005 The block SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 The block SHALL have port clr  input  1  request full memory clear.
REQ-007 The block SHALL have port req_valid  input  1  request present.
REQ-008 The block SHALL have port req_ready  output  1  block can accept a request this cycle.
REQ-009 The block SHALL have port mode  input  1  request type: 1 read, 0 write.
REQ-010 The block SHALL have port address  input  ADDR_W  word address.
REQ-011 The block SHALL have port data_in  input  DATA_W  write data.
REQ-012 The block SHALL have port byte_en  input  DATA_W/8  write byte-lane enables.
REQ-013 The block SHALL have port rsp_valid  output  1  read response valid, one-cycle pulse.
REQ-014 The block SHALL have port rsp_err  output  1  read response error: address >= DEPTH.
REQ-015 The block SHALL have port data_out  output  DATA_W  read data, registered.

Function
REQ-016 The FSM SHALL have states CLEAR and IDLE.
REQ-017 In CLEAR, the FSM SHALL write zero to one word per cycle, counting from 0 to DEPTH-1, then enter IDLE, taking DEPTH cycles in total.
REQ-018 req_ready SHALL be 1 only when the state is IDLE and clr is 0, and SHALL be derived combinationally.
REQ-019 A request SHALL be accepted on an edge where req_valid and req_ready are both 1; otherwise it SHALL have no effect.
REQ-020 An accepted write SHALL update only the byte lanes with byte_en=1 at the accepting edge; byte_en=0 SHALL leave the word unchanged.
REQ-021 An accepted read SHALL load data_out and assert rsp_valid for exactly one cycle starting at the accepting edge (latency 1).
REQ-022 data_out SHALL hold its value until the next accepted read.
REQ-023 Back-to-back requests SHALL be sustained at one per cycle.
REQ-024 A read accepted in the cycle after a write to the same address SHALL return the new data.
REQ-025 A write with address >= DEPTH SHALL be dropped.
REQ-026 A read with address >= DEPTH SHALL return data_out=0 with rsp_err=1; rsp_err SHALL be 0 on all other responses.
REQ-027 clr=1 in IDLE SHALL enter CLEAR with the counter at 0, and a request in that cycle SHALL NOT be accepted.
REQ-028 clr=1 while in CLEAR SHALL restart the counter at 0.
REQ-029 rsp_valid SHALL be 0 in CLEAR except for the response to a read accepted on the edge that enters CLEAR.

Reset
REQ-030 rst_n=0 at an edge SHALL force state CLEAR, counter 0, rsp_valid 0, rsp_err 0, and data_out 0.
REQ-031 Reset during CLEAR or IDLE SHALL restart the clear from address 0.
REQ-032 The memory SHALL read all-zero after reset completes.

Structure
REQ-033 A shared package mem_pkg SHALL hold the state encoding (CLEAR, IDLE) and the constants MODE_READ=1 and MODE_WRITE=0.
REQ-034 Storage SHALL be a sub-module mem_array providing a single write port with byte enables and a registered read port.
REQ-035 The FSM, clear counter, handshake, and range check SHALL reside in mem_bank.

Verification
REQ-036 Reset, then wait: req_ready=0 for 256 cycles, then 1; a read of address 5 returns 0 with rsp_err=0.
REQ-037 Write addr 2 = 30 (byte_en=F), write addr 4 = 40, read 2, read 4, issued back-to-back: rsp_valid pulses on 2 consecutive cycles with data_out 30 then 40.
REQ-038 Write addr 7 = 0x11223344, then write 0xAABBCCDD with byte_en=0101, then read 7: data_out=0x11BB33DD.
REQ-039 With DEPTH=200: write 0x55 to addr 210, then read 210: data_out=0, rsp_err=1; a read of addr 199 returns 0, rsp_err=0.
REQ-040 In IDLE, assert clr together with a write to addr 3: the write is not accepted, req_ready=0 for 256 cycles, and a later read of addr 3 returns 0.
REQ-041 Assert rst_n=0 at CLEAR count 100: after release, req_ready stays 0 for a full 256 cycles.
